// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: valid/ready byte handshake into the UART TX controller.
// master drives tx_valid/tx_data (+parity_odd with UART_TX_PARITY_EN); slave drives tx_ready.
interface uart_tx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
`ifdef UART_TX_PARITY_EN
  logic              parity_odd;

  modport master (
    output tx_valid, tx_data, parity_odd,
    input  tx_ready
  );
  modport slave (
    input  tx_valid, tx_data, parity_odd,
    output tx_ready
  );
`else
  modport master (
    output tx_valid, tx_data,
    input  tx_ready
  );
  modport slave (
    input  tx_valid, tx_data,
    output tx_ready
  );
`endif
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit FSM, start/data/[parity]/stop at baud_div_i+1 clocks per bit.
// Ports: clk, hard_rst (async), soft_rst_i, baud_div_i, tx_if (slave), tx_out_o, busy_o,
// frame_done_o. Macro UART_TX_PARITY_EN adds tx_if.parity_odd and a parity bit.
module uart_tx_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic             clk,
  input  logic             hard_rst,
  input  logic             soft_rst_i,
  input  logic [DIV_W-1:0] baud_div_i,
  uart_tx_ctrl_if.slave    tx_if,
  output logic             tx_out_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  baud_q;
  logic [DIV_W-1:0]  div_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`endif
  logic              tick;

  // Last clock of the current bit period.
  assign tick = (baud_q == div_q);

  assign tx_out_o       = tx_q;
  assign busy_o         = busy_q;
  assign frame_done_o   = done_q;
  assign tx_if.tx_ready = ready_q;

  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (soft_rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) begin
        baud_q <= tick ? '0 : baud_q + 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          // ready_q is high exactly while idle
          if (tx_if.tx_valid) begin
            shift_q <= tx_if.tx_data;
            div_q   <= baud_div_i;
`ifdef UART_TX_PARITY_EN
            par_q   <= (^tx_if.tx_data) ^ tx_if.parity_odd;
`endif
            state_q <= S_START;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_q == LAST) begin
              bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= S_PAR;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PAR: begin
          if (tick) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed frames with a scoreboard queue and a negedge
// monitor that checks every serial sample against the queued frame.
module tb_uart_tx_ctrl;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic             clk = 1'b0;
  logic             clk_en = 1'b0;
  logic             hard_rst = 1'b0;
  logic             soft_rst = 1'b0;
  logic [DIV_W-1:0] baud_div = '0;
  logic             tx_out;
  logic             busy;
  logic             frame_done;

  uart_tx_ctrl_if #(.DATA_W(DATA_W)) u_if ();

  uart_tx_ctrl #(
    .DATA_W(DATA_W),
    .DIV_W (DIV_W)
  ) dut (
    .clk         (clk),
    .hard_rst    (hard_rst),
    .soft_rst_i  (soft_rst),
    .baud_div_i  (baud_div),
    .tx_if       (u_if),
    .tx_out_o    (tx_out),
    .busy_o      (busy),
    .frame_done_o(frame_done)
  );

  always #5 if (clk_en) clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                div;
    bit                odd;
    bit                b2b;
    int                abort;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_done = -1000;
  bit   active = 1'b0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops a frame on each start bit and checks every sample.
  initial begin : mon
    rec_t cur;
    bit   expq[$];
    bit   e;
    int   p;
    int   start_cyc;
    forever begin
      @(negedge clk);
      cyc++;
      if (active) begin
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk1("tx_bit", tx_out, e);
          chk1("done_mid", frame_done, 1'b0);
        end else begin
          active = 1'b0;
          chk1("end_tx", tx_out, 1'b1);
          chk1("end_ready", u_if.tx_ready, 1'b1);
          chk1("end_busy", busy, 1'b0);
          if (cur.abort != 0) begin
            chk1("abort_no_done", frame_done, 1'b0);
          end else begin
            chk1("frame_done", frame_done, 1'b1);
            chkn("frame_len", cyc - start_cyc,
                 (cur.div + 1) * (DATA_W + 2 + PBITS));
            if (cur.b2b) chkn("done_spacing", cyc - last_done, 11);
            last_done = cyc;
          end
        end
      end else begin
        chk1("idle_done", frame_done, 1'b0);
        if (tx_out == 1'b0) begin
          if (q.size() == 0) begin
            chkn("spurious_start", 1, 0);
          end else begin
            cur = q.pop_front();
            active = 1'b1;
            start_cyc = cyc;
            if (cur.b2b) chkn("b2b_gap", cyc - last_done, 1);
            chk1("start_busy", busy, 1'b1);
            chk1("start_ready", u_if.tx_ready, 1'b0);
            p = cur.div + 1;
            expq.delete();
            for (int k = 0; k < p; k++) expq.push_back(1'b0);
            for (int b = 0; b < DATA_W; b++)
              for (int k = 0; k < p; k++) expq.push_back(cur.data[b]);
`ifdef UART_TX_PARITY_EN
            for (int k = 0; k < p; k++)
              expq.push_back((^cur.data) ^ cur.odd);
`endif
            for (int k = 0; k < p; k++) expq.push_back(1'b1);
            if (cur.abort > 0)
              while (expq.size() > cur.abort) e = expq.pop_back();
            e = expq.pop_front();
          end
        end
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, input int div,
                      input bit odd, input bit hold, input bit b2b,
                      input int abort);
    rec_t r;
    int   t;
    t = 0;
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = d;
    baud_div      = DIV_W'(div);
`ifdef UART_TX_PARITY_EN
    u_if.parity_odd = odd;
`endif
    while (!u_if.tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!u_if.tx_ready) begin
      chkn("accept_timeout", 0, 1);
      u_if.tx_valid = 1'b0;
    end else begin
      r.data  = d;
      r.div   = div;
      r.odd   = odd;
      r.b2b   = b2b;
      r.abort = abort;
      q.push_back(r);
      @(negedge clk);
      if (!hold) u_if.tx_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || active) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chkn("drain", q.size() + int'(active), 0);
    @(negedge clk);
  endtask

  initial begin
    u_if.tx_valid = 1'b0;
    u_if.tx_data  = '0;
`ifdef UART_TX_PARITY_EN
    u_if.parity_odd = 1'b0;
`endif
    // Asynchronous reset with the clock stopped.
    #3 hard_rst = 1'b1;
    #1;
    chk1("rst_tx", tx_out, 1'b1);
    chk1("rst_ready", u_if.tx_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", frame_done, 1'b0);
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    hard_rst = 1'b0;
    @(negedge clk);

    // Basic 0xA5 frame, 4 clocks per bit.
    send(8'hA5, 3, 1'b0, 1'b0, 1'b0, 0);
    drain();

    // Back-to-back with tx_valid held.
    send(8'h55, 0, 1'b0, 1'b1, 1'b0, 0);
    send(8'h0F, 0, 1'b0, 1'b0, 1'b1, 0);
    drain();

    // Divisor change mid-frame.
    send(8'hC3, 3, 1'b0, 1'b0, 1'b0, 0);
    repeat (9) @(negedge clk);
    baud_div = DIV_W'(7);
    send(8'h3C, 7, 1'b0, 1'b0, 1'b0, 0);
    drain();

    // soft_rst at clock 13 of a frame.
    send(8'h96, 3, 1'b0, 1'b0, 1'b0, 13);
    repeat (12) @(negedge clk);
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    chk1("abort_ready", u_if.tx_ready, 1'b1);
    send(8'h5A, 3, 1'b0, 1'b0, 1'b0, 0);
    drain();

    // soft_rst together with tx_valid: no transfer.
    soft_rst = 1'b1;
    u_if.tx_valid = 1'b1;
    u_if.tx_data = 8'hFF;
    baud_div = DIV_W'(3);
    @(negedge clk);
    chk1("sr_v_ready", u_if.tx_ready, 1'b1);
    chk1("sr_v_busy", busy, 1'b0);
    chk1("sr_v_tx", tx_out, 1'b1);
    soft_rst = 1'b0;
    u_if.tx_valid = 1'b0;
    repeat (3) @(negedge clk);

    // hard_rst mid-frame takes effect without a clock edge.
    send(8'hF0, 2, 1'b0, 1'b0, 1'b0, 6);
    repeat (5) @(negedge clk);
    #1 hard_rst = 1'b1;
    #1;
    chk1("hr_tx", tx_out, 1'b1);
    chk1("hr_busy", busy, 1'b0);
    chk1("hr_ready", u_if.tx_ready, 1'b1);
    chk1("hr_done", frame_done, 1'b0);
    @(negedge clk);
    hard_rst = 1'b0;
    send(8'h81, 1, 1'b0, 1'b0, 1'b0, 0);
    drain();

`ifdef UART_TX_PARITY_EN
    send(8'hA5, 3, 1'b0, 1'b0, 1'b0, 0);
    drain();
    send(8'hA5, 3, 1'b1, 1'b0, 1'b0, 0);
    drain();
`endif

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Control FSM for the UART transmit datapath.
- Accepts a byte over a valid/ready handshake, then sequences the start, data, optional parity and stop bits onto the serial line.
- Owns two internal wrap-around counters:
  - a baud-period counter, which sets clocks per bit;
  - a bit-index counter, which tracks the current data bit.
- Sits between the TX FIFO/host interface and the tx pin.

Parameters:
- DATA_W, 8: data bits per frame; legal range 5..9.
- DIV_W, 16: width of the baud divisor and of the baud counter.

Ports:
- clk  in  1  system clock.
- hard_rst  in  1  asynchronous reset, active-high.
- soft_rst  in  1  synchronous clear, active-high; aborts any frame in progress.
- baud_div  in  DIV_W  clocks per bit minus 1.
- tx_data  in  DATA_W  byte to send; sampled only on the handshake edge.
- tx_valid  in  1  requester has data.
- tx_ready  out  1  controller can accept; high only in IDLE.
- tx_out  out  1  serial line; idle level is 1.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (hard_rst async, or soft_rst sync; hard_rst has priority):
  - state=IDLE, tx_out=1, tx_ready=1, busy=0, frame_done=0;
  - both counters and the shift register cleared.
- All outputs are registered. Nothing is driven combinationally from inputs.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Handshake:
  - Transfer occurs on the rising edge where tx_valid && tx_ready.
  - tx_data is loaded into the shift register and baud_div into a holding register.
  - Changes to baud_div mid-frame are ignored.
  - tx_valid while tx_ready=0 is ignored and has no side effects.
- After the accepting edge: state=START, tx_out=0, tx_ready=0, busy=1.
- Bit timing:
  - Every bit lasts exactly latched_div+1 clocks.
  - The baud counter counts 0..latched_div. At terminal count it wraps to 0 and the FSM advances to the next bit.
  - latched_div=0 is legal and gives 1 clock per bit.
- DATA:
  - Bits are sent LSB first.
  - The bit counter runs 0..DATA_W-1 and wraps to 0 when leaving DATA.
  - The shift register shifts right once per bit boundary.
- STOP: tx_out=1 for one bit period.
- Edge ending STOP:
  - state=IDLE, tx_ready=1, busy=0, frame_done=1 for exactly one cycle.
- Back-to-back frames:
  - If tx_valid is held high, the next transfer occurs on the first edge in IDLE.
  - The line therefore has a minimum of 1 idle clock (high) between frames.
- Frame length, acceptance edge to frame_done edge: (latched_div+1)*(DATA_W+2) clocks, plus (latched_div+1) with parity.
- soft_rst mid-frame:
  - Returns to IDLE on the next edge with tx_out=1.
  - frame_done is not pulsed.
  - soft_rst in the same cycle as tx_valid wins; no transfer occurs.
- hard_rst mid-frame: outputs go to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds an input port parity_odd (1 bit), latched at the handshake.
  - The PARITY state is inserted between DATA and STOP for one bit period.
  - tx_out = XOR of the data bits, inverted when parity_odd=1.
- Undefined:
  - No parity_odd port and no PARITY state.
  - The FSM goes DATA -> STOP directly.

Test Plan:
- Reset: assert hard_rst with no clock edge -> tx_out=1, tx_ready=1, busy=0, frame_done=0 immediately.
- Basic frame: DATA_W=8, baud_div=3, tx_data=0xA5, one-cycle tx_valid -> tx_out shows the following, each bit 4 clocks wide:
  - start bit 0;
  - data bits 1,0,1,0,0,1,0,1;
  - stop bit 1.
  - frame_done pulses 40 clocks after the accepting edge.
- Back-to-back: baud_div=0, tx_valid held high with 0x55 then 0x0F -> two 10-clock frames separated by exactly 1 idle-high clock; two frame_done pulses 11 clocks apart.
- Divisor change: change baud_div from 3 to 7 mid-frame -> current frame keeps 4 clocks/bit; next frame uses 8 clocks/bit.
- Abort: soft_rst at clock 13 of a baud_div=3 frame -> tx_out=1, tx_ready=1 next cycle; no frame_done; the next frame transmits correctly.
- Parity (UART_TX_PARITY_EN defined):
  - 0xA5 with parity_odd=0 -> parity bit 0, frame_done at 44 clocks.
  - 0xA5 with parity_odd=1 -> parity bit 1.
